// File: rtl/wb_pkg.sv
// Shared defaults and requester identifiers for the writeback arbiter slice.
package wb_pkg;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned NREG = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: issue sets a destination bit, the register-file write clears it.
module wb_scoreboard #(
    parameter int unsigned AW   = wb_pkg::AW,
    parameter int unsigned NREG = wb_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic [AW-1:0]   src1,
    input  logic [AW-1:0]   src2,
    output logic [NREG-1:0] busy_vec,
    output logic            hazard_c
);

    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        busy_d = busy_vec;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_d;
    end

    assign hazard_c = busy_vec[src1] | busy_vec[src2];

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter between ALU and load unit, with a one-cycle
// register-file write stage and a pending-write scoreboard.
module wb_arbiter #(
    parameter int unsigned DW   = wb_pkg::DW,
    parameter int unsigned AW   = wb_pkg::AW,
    parameter int unsigned NREG = wb_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   src1,
    input  logic [AW-1:0]   src2,
    output logic            hazard,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_rd,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy_vec,
    output logic            wb_err
);
    import wb_pkg::req_id_t;
    import wb_pkg::REQ_ALU;
    import wb_pkg::REQ_MEM;

    req_id_t       last_q;
    req_id_t       last_d;
    logic          xfer_c;
    logic [AW-1:0] sel_rd_c;
    logic [DW-1:0] sel_data_c;

    // Grant: a lone requester wins; on conflict the one not granted last wins.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        last_d    = last_q;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                alu_ready = (last_q == REQ_MEM);
                mem_ready = (last_q == REQ_ALU);
            end else begin
                alu_ready = alu_valid;
                mem_ready = mem_valid;
            end
        end
        if (alu_ready)      last_d = REQ_ALU;
        else if (mem_ready) last_d = REQ_MEM;
    end

    assign xfer_c     = alu_ready | mem_ready;
    assign sel_rd_c   = alu_ready ? alu_rd   : mem_rd;
    assign sel_data_c = alu_ready ? alu_data : mem_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= REQ_MEM;
        else     last_q <= last_d;
    end

    // Write stage; rd/data hold between writes, wb_err is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            rf_wen <= xfer_c;
            if (xfer_c) begin
                rf_rd    <= sel_rd_c;
                rf_wdata <= sel_data_c;
                if (!busy_vec[sel_rd_c]) wb_err <= 1'b1;
            end
        end
    end

    wb_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (rf_wen),
        .clr_idx  (rf_rd),
        .src1     (src1),
        .src2     (src2),
        .busy_vec (busy_vec),
        .hazard_c (hazard)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset-mid-operation sequence,
// and randomized traffic against a transaction-level reference model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]  alu_rd, mem_rd, iss_rd, src1, src2, rf_rd;
    logic [15:0] alu_data, mem_data, rf_wdata, busy_vec;
    logic        iss_valid, hazard, rf_wen, wb_err;

    int n_vec = 0;
    int n_bad = 0;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .src1(src1), .src2(src2),
        .hazard(hazard), .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Losing requester must present identical valid/rd/data until accepted.
    logic        ha = 1'b0, hm = 1'b0;
    logic [3:0]  pa_rd, pm_rd;
    logic [15:0] pa_d, pm_d;
    always @(posedge clk) begin
        if (ha && !rst) chk("alu_hold", 32'({alu_valid, alu_rd, alu_data}), 32'({1'b1, pa_rd, pa_d}));
        if (hm && !rst) chk("mem_hold", 32'({mem_valid, mem_rd, mem_data}), 32'({1'b1, pm_rd, pm_d}));
        ha = alu_valid && !alu_ready && !rst;
        hm = mem_valid && !mem_ready && !rst;
        pa_rd = alu_rd; pa_d = alu_data;
        pm_rd = mem_rd; pm_d = mem_data;
    end

    // Reference model: which requester owns the next conflict, set of pending
    // destinations, the write currently presented to the register file.
    bit          m_busy[16];
    bit          m_err, m_wen;
    logic [3:0]  m_rd;
    logic [15:0] m_wd;
    int          m_last;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        m_err = 1'b0; m_wen = 1'b0; m_rd = '0; m_wd = '0; m_last = 1;
    endtask

    task automatic m_grant(output bit ga, output bit gm);
        ga = 1'b0; gm = 1'b0;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (m_last == 1) ga = 1'b1;
                else             gm = 1'b1;
            end else begin
                ga = alu_valid;
                gm = mem_valid;
            end
        end
    endtask

    task automatic model_check();
        bit ga, gm;
        logic [15:0] bv;
        m_grant(ga, gm);
        for (int i = 0; i < 16; i++) bv[i] = m_busy[i];
        chk("r_alu_ready", 32'(alu_ready), 32'(ga));
        chk("r_mem_ready", 32'(mem_ready), 32'(gm));
        chk("r_rf_wen",    32'(rf_wen),    32'(m_wen));
        chk("r_rf_rd",     32'(rf_rd),     32'(m_rd));
        chk("r_rf_wdata",  32'(rf_wdata),  32'(m_wd));
        chk("r_busy_vec",  32'(busy_vec),  32'(bv));
        chk("r_wb_err",    32'(wb_err),    32'(m_err));
        chk("r_hazard",    32'(hazard),    32'(m_busy[src1] | m_busy[src2]));
    endtask

    task automatic model_step(input bit ga, input bit gm);
        logic [3:0]  rd;
        logic [15:0] d;
        if (rst) begin
            model_reset();
        end else begin
            rd = ga ? alu_rd : mem_rd;
            d  = ga ? alu_data : mem_data;
            if ((ga || gm) && !m_busy[rd]) m_err = 1'b1;
            if (m_wen) m_busy[m_rd] = 1'b0;
            if (iss_valid) m_busy[iss_rd] = 1'b1;
            m_wen = ga || gm;
            if (ga || gm) begin m_rd = rd; m_wd = d; end
            if (ga) m_last = 0;
            else if (gm) m_last = 1;
        end
    endtask

    typedef struct {
        logic alu_v; logic [3:0] alu_rd; logic [15:0] alu_d;
        logic mem_v; logic [3:0] mem_rd; logic [15:0] mem_d;
        logic iss_v; logic [3:0] iss_rd; logic [3:0] s1; logic [3:0] s2;
        logic e_ar; logic e_mr; logic e_wen; logic [3:0] e_rd; logic [15:0] e_wd;
        logic e_haz; logic e_err; logic [15:0] e_busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b1, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 16'h0002};
        tbl[2]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b1, 4'd5, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 16'h0006};
        tbl[3]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 16'h0026};
        tbl[4]  = '{1'b0, 4'd0, 16'h0,    1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1111, 1'b0, 1'b0, 16'h0026};
        tbl[5]  = '{1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1, 4'd2, 16'h2222, 1'b1, 1'b0, 16'h0024};
        tbl[6]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0020};
        tbl[7]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0020};
        tbl[8]  = '{1'b0, 4'd0, 16'h0,    1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5, 16'hBEEF, 1'b0, 1'b0, 16'h0020};
        tbl[9]  = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b1, 16'h0020};
        tbl[10] = '{1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 16'h7777, 1'b0, 1'b1, 16'h0020};

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        iss_valid = 1'b0; iss_rd = '0; src1 = '0; src2 = '0;
        #2;
        chk("reset_rf_wen",    32'(rf_wen),    32'd0);
        chk("reset_rf_rd",     32'(rf_rd),     32'd0);
        chk("reset_rf_wdata",  32'(rf_wdata),  32'd0);
        chk("reset_busy_vec",  32'(busy_vec),  32'd0);
        chk("reset_wb_err",    32'(wb_err),    32'd0);
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        chk("reset_alu_ready", 32'(alu_ready), 32'd0);
        chk("reset_mem_ready", 32'(mem_ready), 32'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table: inputs held for one cycle, outputs sampled mid-cycle.
        for (int i = 0; i < 11; i++) begin
            alu_valid = tbl[i].alu_v; alu_rd = tbl[i].alu_rd; alu_data = tbl[i].alu_d;
            mem_valid = tbl[i].mem_v; mem_rd = tbl[i].mem_rd; mem_data = tbl[i].mem_d;
            iss_valid = tbl[i].iss_v; iss_rd = tbl[i].iss_rd; src1 = tbl[i].s1; src2 = tbl[i].s2;
            @(negedge clk);
            chk($sformatf("t%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
            chk($sformatf("t%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
            chk($sformatf("t%0d_rf_wen", i),    32'(rf_wen),    32'(tbl[i].e_wen));
            chk($sformatf("t%0d_rf_rd", i),     32'(rf_rd),     32'(tbl[i].e_rd));
            chk($sformatf("t%0d_rf_wdata", i),  32'(rf_wdata),  32'(tbl[i].e_wd));
            chk($sformatf("t%0d_hazard", i),    32'(hazard),    32'(tbl[i].e_haz));
            chk($sformatf("t%0d_wb_err", i),    32'(wb_err),    32'(tbl[i].e_err));
            chk($sformatf("t%0d_busy_vec", i),  32'(busy_vec),  32'(tbl[i].e_busy));
            @(posedge clk); #1;
        end

        // Reset while a write is on the register-file port.
        alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b1; iss_rd = 4'd3; src1 = '0; src2 = '0;
        @(posedge clk); #1;
        iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h3333;
        @(negedge clk);
        chk("rst_pre_alu_ready", 32'(alu_ready), 32'd1);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        chk("rst_pre_rf_wen", 32'(rf_wen), 32'd1);
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'hAAAA;
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'hBBBB;
        #1;
        chk("rst_rf_wen",    32'(rf_wen),    32'd0);
        chk("rst_rf_rd",     32'(rf_rd),     32'd0);
        chk("rst_rf_wdata",  32'(rf_wdata),  32'd0);
        chk("rst_busy_vec",  32'(busy_vec),  32'd0);
        chk("rst_wb_err",    32'(wb_err),    32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_no_replay", 32'(rf_wen), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_alu_ready", 32'(alu_ready), 32'd1);
        chk("post_mem_ready", 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        chk("post_mem_ready2", 32'(mem_ready), 32'd1);
        chk("post_rf_wen",     32'(rf_wen),    32'd1);
        chk("post_rf_rd",      32'(rf_rd),     32'd1);
        chk("post_rf_wdata",   32'(rf_wdata),  32'h0000AAAA);
        chk("post_wb_err",     32'(wb_err),    32'd1);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("post2_rf_wen",    32'(rf_wen),    32'd1);
        chk("post2_rf_rd",     32'(rf_rd),     32'd2);
        chk("post2_rf_wdata",  32'(rf_wdata),  32'h0000BBBB);

        // Randomized traffic against the reference model.
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            bit ga, gm;
            @(negedge clk);
            model_check();
            @(posedge clk);
            m_grant(ga, gm);
            model_step(ga, gm);
            #1;
            rst = ($urandom_range(63) == 0);
            if (rst) model_reset();
            if (!(alu_valid && !ga)) begin
                alu_valid = 1'($urandom_range(1));
                alu_rd    = 4'($urandom);
                alu_data  = 16'($urandom);
            end
            if (!(mem_valid && !gm)) begin
                mem_valid = 1'($urandom_range(1));
                mem_rd    = 4'($urandom);
                mem_data  = 16'($urandom);
            end
            iss_valid = ($urandom_range(2) == 0);
            iss_rd    = 4'($urandom);
            src1      = 4'($urandom);
            src2      = 4'($urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16, register data width.
REQ-002 SHALL have parameter AW, default 4, register index width.
REQ-003 SHALL have parameter NREG, default 16, register count (2**AW).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 alu_valid  in  1  ALU writeback request.
REQ-007 alu_ready  out  1  ALU request accepted this cycle.
REQ-008 alu_rd  in  AW  ALU destination index.
REQ-009 alu_data  in  DW  ALU writeback data.
REQ-010 mem_valid / mem_ready / mem_rd / mem_data  in / out / in / in  1 / 1 / AW / DW  load-unit request, same semantics as ALU.
REQ-011 iss_valid  in  1  issue stage reserves a destination.
REQ-012 iss_rd  in  AW  reserved destination index.
REQ-013 src1, src2  in  AW  source indices of instruction in issue.
REQ-014 hazard  out  1  src1 or src2 has a pending write.
REQ-015 rf_wen  out  1  register-file write enable.
REQ-016 rf_rd  out  AW  register-file write index.
REQ-017 rf_wdata  out  DW  register-file write data.
REQ-018 busy_vec  out  NREG  pending-write scoreboard.
REQ-019 wb_err  out  1  sticky: write accepted to a non-busy register.

Function
REQ-020 Transfer on a port SHALL occur when valid and ready are both 1 at a rising edge; at most one transfer per cycle in total.
REQ-021 ready SHALL be combinational from valid and grant pointer; ready SHALL be 0 whenever valid is 0.
REQ-022 One valid requester SHALL be granted immediately.
REQ-023 Both valid SHALL be resolved round-robin: grant the requester not granted last; the pointer updates only on a transfer.
REQ-024 Grant pointer SHALL reset to "last = MEM", so ALU wins the first conflict.
REQ-025 The losing requester SHALL keep valid, rd and data stable until ready; bench asserts this.
REQ-026 Accepted rd/data SHALL appear on rf_rd/rf_wdata with rf_wen=1 exactly one cycle after the transfer edge, for exactly one cycle; latency is fixed at 1.
REQ-027 Back-to-back transfers SHALL produce rf_wen=1 on consecutive cycles with no bubble.
REQ-028 rf_rd/rf_wdata SHALL hold their last value when rf_wen=0.
REQ-029 iss_valid=1 SHALL set busy_vec[iss_rd] at the next edge.
REQ-030 rf_wen=1 SHALL clear busy_vec[rf_rd] at the same edge the register file writes.
REQ-031 Set and clear of the same index at one edge SHALL leave the bit set.
REQ-032 hazard SHALL equal busy_vec[src1] | busy_vec[src2], combinational from registered state.
REQ-033 Index 0 SHALL have no special treatment.
REQ-034 A transfer whose rd is not busy at the transfer edge SHALL still be written and SHALL set wb_err at that edge; wb_err clears only on reset.

Reset
REQ-035 rst=1 SHALL immediately force rf_wen=0, rf_rd=0, rf_wdata=0, busy_vec=0, wb_err=0, grant pointer=MEM.
REQ-036 While rst=1, alu_ready and mem_ready SHALL be 0 and no transfer SHALL occur.
REQ-037 A write in flight at reset assertion SHALL be dropped and not replayed.

Structure
REQ-038 Package wb_pkg SHALL hold DW, AW and NREG defaults and typedef enum req_id_t {REQ_ALU, REQ_MEM}.
REQ-039 The scoreboard (REQ-029..REQ-032) SHALL be a sub-module named wb_scoreboard; arbitration and output register stay in wb_arbiter.

Verification
REQ-040 Single ALU: alu_valid, rd=5, data=16'hBEEF -> alu_ready=1 same cycle; next cycle rf_wen=1, rf_rd=5, rf_wdata=16'hBEEF.
REQ-041 Conflict: both valid (ALU rd=1 data=16'h1111, MEM rd=2 data=16'h2222) held -> ALU granted first, MEM next cycle; rf writes 1 then 2 on consecutive cycles.
REQ-042 Scoreboard: iss rd=3, then src1=3 -> hazard=1; MEM writes rd=3 -> hazard=0 the cycle after rf_wen.
REQ-043 Collision: busy[4]=1; at one edge iss_valid with rd=4 and rf_wen with rf_rd=4 -> busy_vec[4] stays 1.
REQ-044 Error: write rd=7 with busy_vec=0 -> rf write occurs, wb_err=1 and stays 1 until rst.
REQ-045 Reset mid-op: rst asserted while rf_wen=1 -> rf_wen=0, busy_vec=0 immediately; first conflict after release grants ALU.
